// File: rtl/portfolio_loader.sv
// portfolio_loader: accumulates signed position records, launches the risk engine and returns its scanning risk.
// Build option: define POS_SAT_EN to saturate position overflow instead of wrapping.
module portfolio_loader #(
   parameter int NUM_POS  = 8,
   parameter int POS_W    = 16,
   parameter int RISK_LAT = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       rec_valid,
   output logic                       rec_ready,
   input  logic [$clog2(NUM_POS)-1:0] rec_idx,
   input  logic [POS_W-1:0]           rec_qty,
   input  logic                       rec_side,
   input  logic                       rec_last,
   input  logic [POS_W-1:0]           psr_in,
   output logic [NUM_POS*POS_W-1:0]   position,
   output logic [POS_W-1:0]           priceScanRange,
   output logic                       risk_en,
   input  logic [POS_W-1:0]           risk_in,
   output logic                       result_valid,
   input  logic                       result_ready,
   output logic [POS_W-1:0]           result_risk,
   output logic                       result_ovf
);

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [POS_W-1:0] POS_MIN  = {1'b1, {(POS_W-1){1'b0}}};
`ifdef POS_SAT_EN
   localparam logic [POS_W-1:0] POS_MAX  = {1'b0, {(POS_W-1){1'b1}}};
`endif
   localparam logic [3:0]       LAT_LAST = 4'(RISK_LAT - 1);

   state_t           r_state;
   logic [POS_W-1:0] r_pos [NUM_POS];
   logic [POS_W-1:0] r_psr;
   logic             r_risk_en;
   logic             r_result_valid;
   logic [POS_W-1:0] r_result_risk;
   logic             r_result_ovf;
   logic             r_ovf;
   logic [3:0]       r_lat_cnt;

   logic             w_rec_hs;
   logic             w_neg_ovf;
   logic [POS_W-1:0] w_eq;
   logic [POS_W-1:0] w_cur;
   logic [POS_W:0]   w_sum_ext;
   logic             w_add_ovf;
   logic [POS_W-1:0] w_new_pos;
   logic             w_rec_ovf;

   assign w_rec_hs  = rec_valid & (r_state == ST_LOAD);
   // Negating the most negative value is the only way the signed quantity itself can overflow.
   assign w_neg_ovf = rec_side & (rec_qty == POS_MIN);
   assign w_cur     = r_pos[rec_idx];

`ifdef POS_SAT_EN
   assign w_eq      = w_neg_ovf ? POS_MAX : (rec_side ? -rec_qty : rec_qty);
`else
   assign w_eq      = rec_side ? -rec_qty : rec_qty;
`endif

   assign w_sum_ext = {w_cur[POS_W-1], w_cur} + {w_eq[POS_W-1], w_eq};
   assign w_add_ovf = w_sum_ext[POS_W] ^ w_sum_ext[POS_W-1];

`ifdef POS_SAT_EN
   assign w_new_pos = w_add_ovf ? (w_sum_ext[POS_W] ? POS_MIN : POS_MAX) : w_sum_ext[POS_W-1:0];
`else
   assign w_new_pos = w_sum_ext[POS_W-1:0];
`endif

   assign w_rec_ovf = w_neg_ovf | w_add_ovf;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= ST_LOAD;
         for (int i = 0; i < NUM_POS; i++) r_pos[i] <= '0;
         r_psr          <= '0;
         r_risk_en      <= 1'b0;
         r_result_valid <= 1'b0;
         r_result_risk  <= '0;
         r_result_ovf   <= 1'b0;
         r_ovf          <= 1'b0;
         r_lat_cnt      <= '0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (w_rec_hs) begin
                  r_pos[rec_idx] <= w_new_pos;
                  if (w_rec_ovf) r_ovf <= 1'b1;
                  if (rec_last) begin
                     r_psr     <= psr_in;
                     r_risk_en <= 1'b1;
                     r_lat_cnt <= '0;
                     r_state   <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               r_lat_cnt <= r_lat_cnt + 4'd1;
               if (r_lat_cnt == LAT_LAST) begin
                  r_result_risk  <= risk_in;
                  r_result_ovf   <= r_ovf;
                  r_result_valid <= 1'b1;
                  r_state        <= ST_DONE;
               end
            end
            ST_DONE: begin
               // Clearing the bank here lets the next portfolio start from zero without an extra cycle.
               if (r_result_valid && result_ready) begin
                  r_result_valid <= 1'b0;
                  r_risk_en      <= 1'b0;
                  for (int i = 0; i < NUM_POS; i++) r_pos[i] <= '0;
                  r_ovf          <= 1'b0;
                  r_state        <= ST_LOAD;
               end
            end
            default: r_state <= ST_LOAD;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_POS; gi++) begin : g_pos_out
         assign position[gi*POS_W +: POS_W] = r_pos[gi];
      end
   endgenerate

   assign rec_ready      = (r_state == ST_LOAD);
   assign priceScanRange = r_psr;
   assign risk_en        = r_risk_en;
   assign result_valid   = r_result_valid;
   assign result_risk    = r_result_risk;
   assign result_ovf     = r_result_ovf;

endmodule

// File: tb/tb_portfolio_loader.sv
// Testbench for portfolio_loader: table-driven portfolios, hand-written backpressure/reset sequences,
// and random portfolios checked against an arithmetic model. Honours POS_SAT_EN like the design.
module tb_portfolio_loader;
   localparam int NUM_POS  = 8;
   localparam int POS_W    = 16;
   localparam int RISK_LAT = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic         rec_valid;
   logic         rec_ready;
   logic [2:0]   rec_idx;
   logic [15:0]  rec_qty;
   logic         rec_side;
   logic         rec_last;
   logic [15:0]  psr_in;
   logic [127:0] position;
   logic [15:0]  priceScanRange;
   logic         risk_en;
   logic [15:0]  risk_in;
   logic         result_valid;
   logic         result_ready;
   logic [15:0]  result_risk;
   logic         result_ovf;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   portfolio_loader #(.NUM_POS(NUM_POS), .POS_W(POS_W), .RISK_LAT(RISK_LAT)) dut (
      .clk(clk), .reset(reset),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_idx(rec_idx), .rec_qty(rec_qty),
      .rec_side(rec_side), .rec_last(rec_last), .psr_in(psr_in),
      .position(position), .priceScanRange(priceScanRange), .risk_en(risk_en), .risk_in(risk_in),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_risk(result_risk), .result_ovf(result_ovf)
   );

   // Stand-in risk engine: risk = (sum of positions) * psr, one-edge pipeline, output held at 0 while disabled.
   function automatic logic [15:0] eng_calc(input logic [127:0] pos, input logic [15:0] psr);
      int s = 0;
      logic signed [15:0] p;
      for (int i = 0; i < 8; i++) begin
         p = pos[i*16 +: 16];
         s += int'(p);
      end
      return 16'(s * int'(psr));
   endfunction

   logic [15:0] eng_q;
   always_ff @(posedge clk) eng_q <= eng_calc(position, priceScanRange);
   assign risk_in = risk_en ? eng_q : 16'd0;

   // Reference model of the position bank.
   int m_pos [8];
   bit m_ovf;

   function automatic void model_clear();
      for (int i = 0; i < 8; i++) m_pos[i] = 0;
      m_ovf = 1'b0;
   endfunction

   function automatic int wrap16(input int v);
      logic signed [15:0] t;
      t = 16'(v);
      return int'(t);
   endfunction

   function automatic void model_apply(input int idx, input logic [15:0] qty, input logic side);
      logic signed [15:0] sq;
      int eq;
      int s;
      sq = qty;
      eq = side ? -int'(sq) : int'(sq);
      if (eq > 32767) begin
         m_ovf = 1'b1;
`ifdef POS_SAT_EN
         eq = 32767;
`else
         eq = -32768;
`endif
      end
      s = m_pos[idx] + eq;
      if (s > 32767 || s < -32768) begin
         m_ovf = 1'b1;
`ifdef POS_SAT_EN
         s = (s > 0) ? 32767 : -32768;
`else
         s = wrap16(s);
`endif
      end
      m_pos[idx] = s;
   endfunction

   function automatic logic [127:0] model_bank();
      logic [127:0] b;
      for (int i = 0; i < 8; i++) b[i*16 +: 16] = 16'(m_pos[i]);
      return b;
   endfunction

   function automatic logic [15:0] model_risk(input logic [15:0] psr);
      int s = 0;
      for (int i = 0; i < 8; i++) s += m_pos[i];
      return 16'(s * int'(psr));
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Presents one record and returns #1 after its handshake edge.
   task automatic send_rec(input int idx, input logic [15:0] qty, input logic side, input logic last,
                           input logic [15:0] psr, input logic [15:0] exp_slot);
      int n = 0;
      @(negedge clk);
      rec_valid = 1'b1; rec_idx = 3'(idx); rec_qty = qty; rec_side = side; rec_last = last; psr_in = psr;
      while (!rec_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("rec_ready_timeout", rec_ready, 1);
      @(posedge clk);
      #1;
      rec_valid = 1'b0;
      chk("slot_after_rec", position[idx*16 +: 16], exp_slot);
      $display("rec idx=%0d qty=%0h side=%0d last=%0d -> slot=%0h", idx, qty, side, last, position[idx*16 +: 16]);
   endtask

   // Called #1 after the last-record handshake edge; runs latency, result, backpressure and result handshake.
   task automatic finish_portfolio(input logic [15:0] exp_psr, input logic [127:0] exp_bank,
                                   input logic [15:0] exp_risk, input logic exp_ovf, input int hold);
      chk("risk_en_on", risk_en, 1);
      chk("rec_ready_run", rec_ready, 0);
      chk("psr_latched", priceScanRange, exp_psr);
      chk("bank_run", position, exp_bank);
      for (int k = 1; k <= RISK_LAT; k++) begin
         @(posedge clk);
         #1;
         chk("valid_latency", result_valid, (k == RISK_LAT));
      end
      chk("result_risk", result_risk, exp_risk);
      chk("result_ovf", result_ovf, exp_ovf);
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         rec_valid = (c % 3 == 0); rec_idx = 3'd0; rec_qty = 16'd5; rec_side = 1'b0; rec_last = (c % 2 == 0);
         @(posedge clk);
         #1;
         chk("hold_valid", result_valid, 1);
         chk("hold_risk", result_risk, exp_risk);
         chk("hold_rec_ready", rec_ready, 0);
         chk("hold_bank", position, exp_bank);
      end
      @(negedge clk);
      rec_valid = 1'b0;
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      result_ready = 1'b0;
      chk("valid_cleared", result_valid, 0);
      chk("rec_ready_after", rec_ready, 1);
      chk("risk_en_off", risk_en, 0);
      chk("bank_cleared", position, 128'd0);
      $display("result risk=%0h ovf=%0d (expected %0h/%0d)", result_risk, result_ovf, exp_risk, exp_ovf);
   endtask

   typedef struct {
      int          idx;
      logic [15:0] qty;
      logic        side;
      logic        last;
      logic [15:0] psr;
      logic [15:0] exp_slot;
      logic [15:0] exp_risk;
      logic        exp_ovf;
      int          hold;
   } vec_t;

   vec_t vt [8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] tb_bank;
      logic [15:0]  rq, rpsr;
      logic         rside;
      int           ridx, nrec;

      vt[0] = '{0, 16'd3,     1'b0, 1'b0, 16'd0,   16'd3,     16'd0,     1'b0, 0};
      vt[1] = '{1, 16'd2,     1'b0, 1'b1, 16'd100, 16'd2,     16'd500,   1'b0, 10};
      vt[2] = '{2, 16'd7,     1'b0, 1'b0, 16'd0,   16'd7,     16'd0,     1'b0, 0};
      vt[3] = '{2, 16'd7,     1'b1, 1'b1, 16'd50,  16'd0,     16'd0,     1'b0, 0};
      vt[4] = '{4, 16'h7FFF,  1'b0, 1'b0, 16'd0,   16'h7FFF,  16'd0,     1'b0, 0};
`ifdef POS_SAT_EN
      vt[5] = '{4, 16'd1,     1'b0, 1'b1, 16'd10,  16'h7FFF,  16'hFFF6,  1'b1, 2};
      vt[6] = '{3, 16'h8000,  1'b1, 1'b1, 16'd1,   16'h7FFF,  16'h7FFF,  1'b1, 0};
`else
      vt[5] = '{4, 16'd1,     1'b0, 1'b1, 16'd10,  16'h8000,  16'h0000,  1'b1, 2};
      vt[6] = '{3, 16'h8000,  1'b1, 1'b1, 16'd1,   16'h8000,  16'h8000,  1'b1, 0};
`endif
      vt[7] = '{0, 16'hFFFB,  1'b0, 1'b1, 16'd3,   16'hFFFB,  16'hFFF1,  1'b0, 0};

      reset = 1'b1; rec_valid = 1'b0; rec_idx = '0; rec_qty = '0; rec_side = 1'b0; rec_last = 1'b0;
      psr_in = '0; result_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_rec_ready", rec_ready, 1);
      chk("rst_risk_en", risk_en, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_risk", result_risk, 0);
      chk("rst_ovf", result_ovf, 0);
      chk("rst_bank", position, 128'd0);
      chk("rst_psr", priceScanRange, 0);
      reset = 1'b0;

      // Table-driven portfolios.
      tb_bank = '0;
      for (int v = 0; v < 8; v++) begin
         send_rec(vt[v].idx, vt[v].qty, vt[v].side, vt[v].last, vt[v].psr, vt[v].exp_slot);
         tb_bank[vt[v].idx*16 +: 16] = vt[v].exp_slot;
         if (vt[v].last) begin
            finish_portfolio(vt[v].psr, tb_bank, vt[v].exp_risk, vt[v].exp_ovf, vt[v].hold);
            tb_bank = '0;
         end
      end

      // Reset asserted mid-RUN: everything returns to reset values and no result appears.
      send_rec(5, 16'd9, 1'b0, 1'b0, 16'd0, 16'd9);
      send_rec(6, 16'd4, 1'b0, 1'b1, 16'd20, 16'd4);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("midrun_rst_risk_en", risk_en, 0);
      chk("midrun_rst_valid", result_valid, 0);
      chk("midrun_rst_bank", position, 128'd0);
      chk("midrun_rst_psr", priceScanRange, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_rec_ready", rec_ready, 1);
      chk("post_rst_bank", position, 128'd0);
      repeat (RISK_LAT + 2) begin
         @(posedge clk);
         #1;
         chk("post_rst_no_result", result_valid, 0);
      end
      $display("mid-RUN reset sequence done");

      // Random portfolios against the model.
      model_clear();
      for (int p = 0; p < 15; p++) begin
         nrec = $urandom_range(1, 6);
         rpsr = 16'($urandom_range(1, 1000));
         for (int r = 0; r < nrec; r++) begin
            ridx  = $urandom_range(0, 7);
            rside = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) rq = 16'($urandom);
            else rq = 16'($urandom_range(0, 200)) - 16'd100;
            model_apply(ridx, rq, rside);
            send_rec(ridx, rq, rside, (r == nrec - 1), rpsr, 16'(m_pos[ridx]));
         end
         finish_portfolio(rpsr, model_bank(), model_risk(rpsr), m_ovf, $urandom_range(0, 3));
         model_clear();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
